// File: rtl/countdown_seq_pkg.sv
// Shared types and constants for the countdown sequencer and its prescaler.
package countdown_seq_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 8;

  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_DIV2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    STEP = 3'd3,
    FIN  = 3'd4,
    ABRT = 3'd5
  } seq_state_e;

endpackage

// File: rtl/step_prescaler.sv
// Idle-cycle counter between step pulses: reload to P, count down, flag zero.
module step_prescaler
  import countdown_seq_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  reload,
  input  logic                  dec,
  input  logic [PRESCALE_W-1:0] reload_value,
  output logic                  at_zero
);

  logic [PRESCALE_W-1:0] pcnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (reload) begin
      pcnt <= reload_value;
    end else if (dec && (pcnt != '0)) begin
      pcnt <= pcnt - PRESCALE_W'(1);
    end
  end

  assign at_zero = (pcnt == '0);

endmodule

// File: rtl/countdown_sequencer.sv
// Command-driven sequencer that loads the down-counter and paces its step pulses.
//   state | meaning
//   IDLE  | ready for a command
//   LOAD  | latch captured value into the counter
//   WAIT  | idle cycles between steps, watching cnt_zero
//   STEP  | one dec or div2 pulse
//   FIN   | done pulse
//   ABRT  | aborted pulse
module countdown_sequencer
  import countdown_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_value,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  input  logic                  cmd_mode,
  input  logic                  abort,
  output logic [WIDTH-1:0]      cnt_in,
  output logic                  cnt_latch,
  output logic                  cnt_dec,
  output logic                  cnt_div2,
  input  logic                  cnt_zero,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [WIDTH-1:0]      step_count
);

  seq_state_e            state;
  logic [WIDTH-1:0]      value_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  mode_q;
  logic [WIDTH-1:0]      steps_q;
  logic                  pre_reload;
  logic                  pre_dec;
  logic                  pre_zero;

  assign pre_reload = (state == LOAD) || (state == STEP);
  assign pre_dec    = (state == WAIT) && !abort && !cnt_zero && !pre_zero;

  step_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clock        (clock),
    .reset_n      (reset_n),
    .reload       (pre_reload),
    .dec          (pre_dec),
    .reload_value (prescale_q),
    .at_zero      (pre_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      value_q    <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_DEC;
      steps_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            value_q    <= cmd_value;
            prescale_q <= cmd_prescale;
            mode_q     <= cmd_mode;
            steps_q    <= '0;
            state      <= LOAD;
          end
        end
        LOAD: state <= abort ? ABRT : WAIT;
        // Abort outranks the zero flag; zero outranks the prescale expiry.
        WAIT: begin
          if (abort) begin
            state <= ABRT;
          end else if (cnt_zero) begin
            state <= FIN;
          end else if (pre_zero) begin
            state <= STEP;
          end
        end
        STEP: begin
          steps_q <= steps_q + WIDTH'(1);
          state   <= abort ? ABRT : WAIT;
        end
        FIN:     state <= IDLE;
        ABRT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == LOAD) || (state == WAIT) || (state == STEP) || (state == FIN);
  assign done       = (state == FIN);
  assign aborted    = (state == ABRT);
  assign cnt_latch  = (state == LOAD);
  assign cnt_dec    = (state == STEP) && (mode_q == MODE_DEC);
  assign cnt_div2   = (state == STEP) && (mode_q == MODE_DIV2);
  assign cnt_in     = value_q;
  assign step_count = steps_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench: sequencer driving a behavioural 8-bit down-counter.
module tb_countdown_sequencer;
  import countdown_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_value;
  logic [7:0] cmd_prescale;
  logic       cmd_mode;
  logic       abort;
  logic [7:0] cnt_in;
  logic       cnt_latch;
  logic       cnt_dec;
  logic       cnt_div2;
  logic       cnt_zero;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  countdown_sequencer #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_value    (cmd_value),
    .cmd_prescale (cmd_prescale),
    .cmd_mode     (cmd_mode),
    .abort        (abort),
    .cnt_in       (cnt_in),
    .cnt_latch    (cnt_latch),
    .cnt_dec      (cnt_dec),
    .cnt_div2     (cnt_div2),
    .cnt_zero     (cnt_zero),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .step_count   (step_count)
  );

  // Counter model: latch > dec > divide_by_two, zero flag combinational.
  logic [7:0] counter_value = 8'd0;
  always @(posedge clock) begin
    if (cnt_latch)     counter_value <= cnt_in;
    else if (cnt_dec)  counter_value <= counter_value - 8'd1;
    else if (cnt_div2) counter_value <= counter_value >> 1;
  end
  assign cnt_zero = (counter_value == 8'd0);

  int cyc = 0;
  always @(posedge clock) cyc++;

  int latch_cnt = 0, dec_cnt = 0, div2_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int multi_cnt = 0, underflow_cnt = 0;
  int latch_cyc = 0, done_cyc = 0, zero_rise_cyc = 0, last_step_cyc = 0;
  int steps_since = 0, first_gap = -1, min_gap = 1000, max_gap = 0;
  logic zero_prev = 1'b1;
  logic [7:0] seq_q[$];

  always @(negedge clock) begin
    if ((int'(cnt_latch) + int'(cnt_dec) + int'(cnt_div2)) > 1) multi_cnt++;
    if (cnt_dec && counter_value == 8'd0) underflow_cnt++;
    if (cnt_latch) begin
      latch_cnt++;
      latch_cyc   = cyc;
      steps_since = 0;
      first_gap   = -1;
      min_gap     = 1000;
      max_gap     = 0;
    end
    if (cnt_dec || cnt_div2) begin
      if (cnt_dec) dec_cnt++;
      if (cnt_div2) div2_cnt++;
      seq_q.push_back(counter_value);
      if (steps_since == 0) first_gap = cyc - latch_cyc;
      else begin
        if (cyc - last_step_cyc < min_gap) min_gap = cyc - last_step_cyc;
        if (cyc - last_step_cyc > max_gap) max_gap = cyc - last_step_cyc;
      end
      last_step_cyc = cyc;
      steps_since++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (aborted) abort_cnt++;
    if (cnt_zero && !zero_prev) zero_rise_cyc = cyc;
    zero_prev = cnt_zero;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] v, input logic [7:0] p, input logic m,
                          input bit hold, output bit accepted);
    cmd_value    = v;
    cmd_prescale = p;
    cmd_mode     = m;
    cmd_valid    = 1'b1;
    accepted     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_end(output bit ended);
    ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done || aborted) begin
        ended = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready);
    end
    checks++;
    if ({cnt_latch, cnt_dec, cnt_div2, done, aborted, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000000",
                         {cnt_latch, cnt_dec, cnt_div2, done, aborted, busy});
    end
    checks++;
    if (step_count !== 8'd0 || cnt_in !== 8'd0) begin
      errors++; $display("FAIL reset_regs: got step_count=%0d cnt_in=%0d expected 0 0", step_count, cnt_in);
    end
  endtask

  task automatic test_dec();
    bit ok, ended;
    int lb = latch_cnt, db = dec_cnt, vb = div2_cnt, nb = done_cnt, ub = underflow_cnt;
    send_cmd(8'd5, 8'd0, MODE_DEC, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dec_accept: got 0 expected 1"); end
    checks++;
    if (cnt_latch !== 1'b1 || cnt_in !== 8'd5) begin
      errors++; $display("FAIL dec_load: got latch=%0b in=%0d expected 1 5", cnt_latch, cnt_in);
    end
    wait_end(ended);
    tick();
    checks++;
    if (!ended) begin errors++; $display("FAIL dec_timeout: got no end expected done"); end
    checks++;
    if (latch_cnt - lb !== 1 || dec_cnt - db !== 5 || div2_cnt - vb !== 0) begin
      errors++; $display("FAIL dec_pulses: got latch=%0d dec=%0d div2=%0d expected 1 5 0",
                         latch_cnt - lb, dec_cnt - db, div2_cnt - vb);
    end
    checks++;
    if (first_gap !== 2 || min_gap !== 2 || max_gap !== 2) begin
      errors++; $display("FAIL dec_spacing: got first=%0d min=%0d max=%0d expected 2 2 2", first_gap, min_gap, max_gap);
    end
    checks++;
    if (done_cyc - zero_rise_cyc !== 1 || done_cnt - nb !== 1) begin
      errors++; $display("FAIL dec_done: got lag=%0d count=%0d expected 1 1", done_cyc - zero_rise_cyc, done_cnt - nb);
    end
    checks++;
    if (step_count !== 8'd5 || counter_value !== 8'd0 || underflow_cnt != ub) begin
      errors++; $display("FAIL dec_final: got steps=%0d counter=%0d underflows=%0d expected 5 0 0",
                         step_count, counter_value, underflow_cnt - ub);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dec_idle: got ready=%0b busy=%0b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_div2();
    bit ok, ended;
    logic [7:0] exp_seq [8];
    int sb = seq_q.size(), vb = div2_cnt, db = dec_cnt, nb = done_cnt;
    exp_seq = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1};
    send_cmd(8'd200, 8'd1, MODE_DIV2, 1'b0, ok);
    wait_end(ended);
    tick();
    checks++;
    if (!ok || !ended) begin errors++; $display("FAIL div2_handshake: got acc=%0b end=%0b expected 1 1", ok, ended); end
    checks++;
    if (div2_cnt - vb !== 8 || dec_cnt - db !== 0) begin
      errors++; $display("FAIL div2_pulses: got div2=%0d dec=%0d expected 8 0", div2_cnt - vb, dec_cnt - db);
    end
    checks++;
    if (first_gap !== 3 || min_gap !== 3 || max_gap !== 3) begin
      errors++; $display("FAIL div2_spacing: got first=%0d min=%0d max=%0d expected 3 3 3", first_gap, min_gap, max_gap);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seq_q.size() <= sb + i) begin
        errors++; $display("FAIL div2_seq%0d: got missing expected %0d", i, exp_seq[i]);
      end else if (seq_q[sb + i] !== exp_seq[i]) begin
        errors++; $display("FAIL div2_seq%0d: got %0d expected %0d", i, seq_q[sb + i], exp_seq[i]);
      end
    end
    checks++;
    if (step_count !== 8'd8 || counter_value !== 8'd0 || done_cnt - nb !== 1) begin
      errors++; $display("FAIL div2_final: got steps=%0d counter=%0d done=%0d expected 8 0 1",
                         step_count, counter_value, done_cnt - nb);
    end
  endtask

  task automatic test_zero_value();
    bit ok, ended;
    int lb = latch_cnt, sb = dec_cnt + div2_cnt;
    send_cmd(8'd0, 8'd3, MODE_DEC, 1'b0, ok);
    wait_end(ended);
    tick();
    checks++;
    if (!ok || !ended) begin errors++; $display("FAIL zero_handshake: got acc=%0b end=%0b expected 1 1", ok, ended); end
    checks++;
    if (done_cyc - latch_cyc !== 2) begin
      errors++; $display("FAIL zero_done_lat: got %0d expected 2", done_cyc - latch_cyc);
    end
    checks++;
    if (latch_cnt - lb !== 1 || (dec_cnt + div2_cnt) - sb !== 0 || step_count !== 8'd0) begin
      errors++; $display("FAIL zero_pulses: got latch=%0d steps=%0d step_count=%0d expected 1 0 0",
                         latch_cnt - lb, (dec_cnt + div2_cnt) - sb, step_count);
    end
  endtask

  task automatic test_abort();
    bit ok, ended;
    int db = dec_cnt, nb = done_cnt, ab = abort_cnt, lb = latch_cnt;
    send_cmd(8'd10, 8'd4, MODE_DEC, 1'b0, ok);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dec_cnt - db == 3) break;
    end
    checks++;
    if (dec_cnt - db !== 3) begin errors++; $display("FAIL abort_reach: got %0d expected 3 steps", dec_cnt - db); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got aborted=%0b busy=%0b ready=%0b expected 1 0 0", aborted, busy, cmd_ready);
    end
    cmd_value = 8'd3; cmd_prescale = 8'd0; cmd_mode = MODE_DEC; cmd_valid = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || counter_value !== 8'd7 || step_count !== 8'd3) begin
      errors++; $display("FAIL abort_hold: got ready=%0b counter=%0d steps=%0d expected 1 7 3",
                         cmd_ready, counter_value, step_count);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cnt_latch !== 1'b1 || cnt_in !== 8'd3 || step_count !== 8'd0) begin
      errors++; $display("FAIL abort_reaccept: got latch=%0b in=%0d steps=%0d expected 1 3 0",
                         cnt_latch, cnt_in, step_count);
    end
    checks++;
    if (dec_cnt - db !== 3 || done_cnt - nb !== 0 || abort_cnt - ab !== 1) begin
      errors++; $display("FAIL abort_counts: got dec=%0d done=%0d aborted=%0d expected 3 0 1",
                         dec_cnt - db, done_cnt - nb, abort_cnt - ab);
    end
    wait_end(ended);
    tick();
    checks++;
    if (!ended || done_cnt - nb !== 1 || step_count !== 8'd3 || latch_cnt - lb !== 2) begin
      errors++; $display("FAIL abort_next_cmd: got end=%0b done=%0d steps=%0d latches=%0d expected 1 1 3 2",
                         ended, done_cnt - nb, step_count, latch_cnt - lb);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ended;
    int lb = latch_cnt, ready_bad = 0;
    bit saw_done = 1'b0;
    send_cmd(8'd2, 8'd0, MODE_DEC, 1'b1, ok);
    for (int i = 0; i < 100; i++) begin
      if (busy && cmd_ready) ready_bad++;
      if (done) begin saw_done = 1'b1; break; end
      tick();
    end
    checks++;
    if (!saw_done || ready_bad != 0) begin
      errors++; $display("FAIL held_ready: got done=%0b ready_while_busy=%0d expected 1 0", saw_done, ready_bad);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || cnt_latch !== 1'b0) begin
      errors++; $display("FAIL held_idle: got ready=%0b latch=%0b expected 1 0", cmd_ready, cnt_latch);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cnt_latch !== 1'b1) begin errors++; $display("FAIL held_accept: got latch=%0b expected 1", cnt_latch); end
    wait_end(ended);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (!ended || latch_cnt - lb !== 2) begin
      errors++; $display("FAIL held_once: got end=%0b latches=%0d expected 1 2", ended, latch_cnt - lb);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int db = dec_cnt, nb, ab, lb, db2;
    send_cmd(8'd50, 8'd5, MODE_DEC, 1'b0, ok);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dec_cnt - db == 1) break;
    end
    tick();
    nb = done_cnt; ab = abort_cnt; lb = latch_cnt; db2 = dec_cnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || step_count !== 8'd0 || cnt_in !== 8'd0) begin
      errors++; $display("FAIL rst_mid_state: got ready=%0b busy=%0b steps=%0d in=%0d expected 1 0 0 0",
                         cmd_ready, busy, step_count, cnt_in);
    end
    checks++;
    if ({cnt_latch, cnt_dec, cnt_div2, done, aborted} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_strobes: got %b expected 00000", {cnt_latch, cnt_dec, cnt_div2, done, aborted});
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_cnt != nb || abort_cnt != ab || latch_cnt != lb || dec_cnt != db2 || counter_value !== 8'd49) begin
      errors++; $display("FAIL rst_mid_quiet: got done=%0d aborted=%0d latch=%0d dec=%0d counter=%0d expected 0 0 0 0 49",
                         done_cnt - nb, abort_cnt - ab, latch_cnt - lb, dec_cnt - db2, counter_value);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (multi_cnt != 0 || underflow_cnt != 0) begin
      errors++; $display("FAIL invariants: got multi_strobe=%0d underflow=%0d expected 0 0", multi_cnt, underflow_cnt);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_value    = 8'd0;
    cmd_prescale = 8'd0;
    cmd_mode     = MODE_DEC;
    abort        = 1'b0;
    test_reset();
    test_dec();
    test_div2();
    test_zero_value();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
